// File: rtl/johnson_phase_decoder_if.sv
// Bus between the upstream Johnson counter side and the phase decoder.
// The master drives the counter code and the clear pulses; the slave (decoder)
// returns the decoded phase, lock status and the revolution/error counters.
interface johnson_phase_decoder_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  localparam int IDX_W = $clog2(2 * WIDTH);

  logic [WIDTH-1:0]   q_in;
  logic               err_clr;
  logic               rev_clr;
  logic               valid;
  logic [2*WIDTH-1:0] phase;
  logic [IDX_W-1:0]   phase_idx;
  logic               locked;
  logic               rev_tick;
  logic [CNT_W-1:0]   rev_cnt;
  logic               err_illegal;
  logic [CNT_W-1:0]   err_cnt;

  modport master (
    output q_in, err_clr, rev_clr,
    input  valid, phase, phase_idx, locked, rev_tick, rev_cnt, err_illegal, err_cnt
  );

  modport slave (
    input  q_in, err_clr, rev_clr,
    output valid, phase, phase_idx, locked, rev_tick, rev_cnt, err_illegal, err_cnt
  );
endinterface

// File: rtl/johnson_phase_decoder.sv
// Johnson (twisted-ring) counter phase decoder.
// Registers each sampled code, decodes it to a one-hot phase and a binary index,
// classifies each step against the previous sample, runs a lock FSM, counts
// completed revolutions while locked and records errors seen while locked.
module johnson_phase_decoder #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  johnson_phase_decoder_if.slave  bus
);
  localparam int PHASES = 2 * WIDTH;
  localparam int IDX_W  = $clog2(PHASES);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  // One step of the twisted ring: shift right, feed back the inverted LSB.
  function automatic logic [WIDTH-1:0] nextCode(input logic [WIDTH-1:0] q);
    return {~q[0], q[WIDTH-1:1]};
  endfunction

  // Walks the ring from all-zeros; returns {legal, phase index}.
  function automatic logic [IDX_W:0] decodeCode(input logic [WIDTH-1:0] q);
    logic [WIDTH-1:0] walk;
    logic [IDX_W:0]   res;
    walk = '0;
    res  = '0;
    for (int k = 0; k < PHASES; k++) begin
      if (q == walk) begin
        res = {1'b1, IDX_W'(k)};
      end
      walk = nextCode(walk);
    end
    return res;
  endfunction

  state_t             r_state;
  logic [GOOD_W-1:0]  r_good;
  logic               r_locked;
  logic [WIDTH-1:0]   r_prev;
  logic               r_havePrev;
  logic               r_valid;
  logic [PHASES-1:0]  r_phase;
  logic [IDX_W-1:0]   r_phaseIdx;
  logic               r_revTick;
  logic [CNT_W-1:0]   r_revCnt;
  logic               r_errIllegal;
  logic [CNT_W-1:0]   r_errCnt;

  logic [IDX_W:0]     w_decode;
  logic               w_legal;
  logic [IDX_W-1:0]   w_idx;
  logic               w_adv;
  logic               w_hold;
  logic               w_jump;
  logic               w_illegal;
  logic               w_wrap;
  logic               w_lockErr;

  assign w_decode  = decodeCode(bus.q_in);
  assign w_legal   = w_decode[IDX_W];
  assign w_idx     = w_decode[IDX_W-1:0];

  // Without a previous sample nothing can be an advance, hold or jump.
  assign w_adv     = r_havePrev && w_legal && (bus.q_in == nextCode(r_prev));
  assign w_hold    = r_havePrev && w_legal && (bus.q_in == r_prev);
  assign w_jump    = r_havePrev && w_legal && !w_adv && !w_hold;
  assign w_illegal = !w_legal;

  // Advancing into phase 0 means the previous code was the last phase.
  assign w_wrap    = (r_state == LOCKED) && w_adv && (w_idx == '0);
  assign w_lockErr = (r_state == LOCKED) && (w_jump || w_illegal);

  // Lock FSM: count consecutive advances, drop out on any jump or illegal code.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= UNLOCKED;
      r_good   <= '0;
      r_locked <= 1'b0;
    end else begin
      case (r_state)
        UNLOCKED: begin
          r_good   <= '0;
          r_locked <= 1'b0;
          if (w_legal) begin
            r_state <= LOCKING;
          end
        end
        LOCKING: begin
          if (w_adv) begin
            if (r_good + 1'b1 == GOOD_W'(LOCK_CNT)) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
              r_good   <= '0;
            end else begin
              r_good <= r_good + 1'b1;
            end
          end else if (w_jump || w_illegal) begin
            r_state  <= UNLOCKED;
            r_good   <= '0;
            r_locked <= 1'b0;
          end
        end
        LOCKED: begin
          if (w_jump || w_illegal) begin
            r_state  <= UNLOCKED;
            r_good   <= '0;
            r_locked <= 1'b0;
          end
        end
        default: begin
          r_state  <= UNLOCKED;
          r_good   <= '0;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  // Registered decode, revolution counting and sticky error tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prev       <= '0;
      r_havePrev   <= 1'b0;
      r_valid      <= 1'b0;
      r_phase      <= '0;
      r_phaseIdx   <= '0;
      r_revTick    <= 1'b0;
      r_revCnt     <= '0;
      r_errIllegal <= 1'b0;
      r_errCnt     <= '0;
    end else begin
      r_prev     <= bus.q_in;
      r_havePrev <= 1'b1;
      r_valid    <= w_legal;
      r_phase    <= w_legal ? (PHASES'(1) << w_idx) : '0;
      r_phaseIdx <= w_legal ? w_idx : '0;
      r_revTick  <= w_wrap;

      if (bus.rev_clr) begin
        r_revCnt <= '0;
      end else if (w_wrap) begin
        r_revCnt <= r_revCnt + 1'b1;
      end

      if (w_lockErr) begin
        r_errIllegal <= 1'b1;
        if (bus.err_clr) begin
          r_errCnt <= CNT_W'(1);
        end else if (r_errCnt != {CNT_W{1'b1}}) begin
          r_errCnt <= r_errCnt + 1'b1;
        end
      end else if (bus.err_clr) begin
        r_errIllegal <= 1'b0;
        r_errCnt     <= '0;
      end
    end
  end

  assign bus.valid       = r_valid;
  assign bus.phase       = r_phase;
  assign bus.phase_idx   = r_phaseIdx;
  assign bus.locked      = r_locked;
  assign bus.rev_tick    = r_revTick;
  assign bus.rev_cnt     = r_revCnt;
  assign bus.err_illegal = r_errIllegal;
  assign bus.err_cnt     = r_errCnt;
endmodule
